// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Package : led_pkg
// Brief   : Shared state encoding and timing helper for the LED driver family.
// Rev     : 1.0 - initial release
// ============================================================================
package led_pkg;

    localparam int TIMER_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } led_state_t;

    // Whole-kHz clocks assumed; fractional kHz is truncated.
    function automatic logic [TIMER_W-1:0] ms_to_cycles(input int unsigned clk_freq,
                                                        input int unsigned ms);
        return TIMER_W'((clk_freq / 1000) * ms);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cycle_timer.sv
`default_nettype none
// ============================================================================
// Module : cycle_timer
// Brief  : Loadable down-counter that parks at zero and flags done there.
// Rev    : 1.0 - initial release
// ============================================================================
module cycle_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/led_pulse_driver.sv
`default_nettype none
// ============================================================================
// Module : led_pulse_driver
// Brief  : Turns single-cycle event strobes into queued, visible LED blinks.
// Rev    : 1.0 - initial release
// ============================================================================
module led_pulse_driver
    import led_pkg::*;
#(
    parameter  int CLK_FREQ        = 50_000_000,
    parameter  int ON_MS           = 100,
    parameter  int OFF_MS          = 100,
    parameter  int MAX_PENDING     = 15,
    parameter  int LED_ACTIVE_HIGH = 1,
    localparam int PW              = $clog2(MAX_PENDING + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          event_in,
    input  logic          clear_in,
    output logic          led_out,
    output logic          busy,
    output logic [PW-1:0] pending,
    output logic          overflow
);

    localparam logic [TIMER_W-1:0] c_on_load  = ms_to_cycles(CLK_FREQ, ON_MS) - 1'b1;
    localparam logic [TIMER_W-1:0] c_off_load = ms_to_cycles(CLK_FREQ, OFF_MS) - 1'b1;
    localparam logic [PW-1:0]      c_pend_max = PW'(MAX_PENDING);
    localparam logic               c_led_lit  = (LED_ACTIVE_HIGH != 0);

    led_state_t           r_state;
    led_state_t           w_state_next;
    logic                 r_led;
    logic                 r_busy;
    logic [PW-1:0]        r_pending;
    logic                 r_overflow;
    logic                 w_timer_load;
    logic [TIMER_W-1:0]   w_timer_value;
    logic                 w_timer_done;
    logic                 w_event;
    logic                 w_relaunch;

    cycle_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_timer_load),
        .i_load_value (w_timer_value),
        .o_done       (w_timer_done)
    );

    // A clear wipes the queue and swallows any event arriving with it.
    assign w_event    = event_in & ~clear_in;
    assign w_relaunch = (r_state == GAP) & w_timer_done &
                        (w_event | ((r_pending != '0) & ~clear_in));

    always_comb begin
        w_state_next  = r_state;
        w_timer_load  = 1'b0;
        w_timer_value = '0;
        case (r_state)
            IDLE: begin
                if (w_event) begin
                    w_state_next  = ON;
                    w_timer_load  = 1'b1;
                    w_timer_value = c_on_load;
                end
            end
            ON: begin
                if (w_timer_done) begin
                    w_state_next  = GAP;
                    w_timer_load  = 1'b1;
                    w_timer_value = c_off_load;
                end
            end
            GAP: begin
                if (w_timer_done) begin
                    if (w_relaunch) begin
                        w_state_next  = ON;
                        w_timer_load  = 1'b1;
                        w_timer_value = c_on_load;
                    end else begin
                        w_state_next  = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Outputs come from the next state so the pin changes on the same edge as the FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_led      <= ~c_led_lit;
            r_busy     <= 1'b0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_led   <= (w_state_next == ON) ? c_led_lit : ~c_led_lit;
            r_busy  <= (w_state_next != IDLE);
            if (clear_in) begin
                r_pending  <= '0;
                r_overflow <= 1'b0;
            end else if (w_relaunch) begin
                if (!event_in) begin
                    r_pending <= r_pending - 1'b1;
                end
            end else if (event_in && (r_state != IDLE)) begin
                if (r_pending == c_pend_max) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_pending <= r_pending + 1'b1;
                end
            end
        end
    end

    assign led_out  = r_led;
    assign busy     = r_busy;
    assign pending  = r_pending;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_led_pulse_driver.sv
`default_nettype none
// ============================================================================
// Module : tb_led_pulse_driver
// Brief  : Scoreboard bench driving active-high and active-low instances.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_led_pulse_driver;

    localparam int c_on_n  = 10;
    localparam int c_off_n = 10;
    localparam int c_maxp  = 3;

    typedef struct packed {
        logic       led;
        logic       busy;
        logic [1:0] pend;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       event_in;
    logic       clear_in;
    logic       led_hi, busy_hi, ovf_hi;
    logic       led_lo, busy_lo, ovf_lo;
    logic [1:0] pend_hi, pend_lo;

    exp_t r_sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   blinks  = 0;
    logic prev_led = 1'b0;

    // Spec-level model: phase length counted up, queue depth tracked directly.
    int   m_state = 0;
    int   m_cnt   = 0;
    int   m_pend  = 0;
    logic m_ovf   = 1'b0;

    always #5 clk = ~clk;

    led_pulse_driver #(
        .CLK_FREQ        (10_000),
        .ON_MS           (1),
        .OFF_MS          (1),
        .MAX_PENDING     (c_maxp),
        .LED_ACTIVE_HIGH (1)
    ) u_dut_hi (
        .clk      (clk),
        .rst_n    (rst_n),
        .event_in (event_in),
        .clear_in (clear_in),
        .led_out  (led_hi),
        .busy     (busy_hi),
        .pending  (pend_hi),
        .overflow (ovf_hi)
    );

    led_pulse_driver #(
        .CLK_FREQ        (10_000),
        .ON_MS           (1),
        .OFF_MS          (1),
        .MAX_PENDING     (c_maxp),
        .LED_ACTIVE_HIGH (0)
    ) u_dut_lo (
        .clk      (clk),
        .rst_n    (rst_n),
        .event_in (event_in),
        .clear_in (clear_in),
        .led_out  (led_lo),
        .busy     (busy_lo),
        .pending  (pend_lo),
        .overflow (ovf_lo)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_bump();
        if (m_pend == c_maxp) m_ovf = 1'b1;
        else                  m_pend++;
    endtask

    task automatic step(input bit ev, input bit clr, input bit rn);
        exp_t e;
        exp_t got;
        bit   ev_eff;
        @(negedge clk);
        event_in = ev;
        clear_in = clr;
        rst_n    = rn;
        if (!rn) begin
            m_state = 0; m_cnt = 0; m_pend = 0; m_ovf = 1'b0;
        end else begin
            ev_eff = ev && !clr;
            case (m_state)
                0: if (ev_eff) begin m_state = 1; m_cnt = 1; end
                1: begin
                    if (ev_eff) model_bump();
                    if (m_cnt == c_on_n) begin m_state = 2; m_cnt = 1; end
                    else m_cnt++;
                end
                default: begin
                    if (m_cnt == c_off_n) begin
                        if (!clr && (m_pend > 0 || ev_eff)) begin
                            m_state = 1; m_cnt = 1;
                            if (!ev_eff) m_pend--;
                        end else begin
                            m_state = 0;
                        end
                    end else begin
                        if (ev_eff) model_bump();
                        m_cnt++;
                    end
                end
            endcase
            if (clr) begin m_pend = 0; m_ovf = 1'b0; end
        end
        e.led  = (m_state == 1);
        e.busy = (m_state != 0);
        e.pend = 2'(m_pend);
        e.ovf  = m_ovf;
        r_sb.push_back(e);

        @(posedge clk);
        #1;
        cyc++;
        check_val("sb_nonempty", 32'(r_sb.size() != 0), 32'd1);
        if (r_sb.size() != 0) begin
            got = r_sb.pop_front();
            check_val("led_hi",  32'(led_hi),  32'(got.led));
            check_val("led_lo",  32'(led_lo),  32'(!got.led));
            check_val("busy_hi", 32'(busy_hi), 32'(got.busy));
            check_val("busy_lo", 32'(busy_lo), 32'(got.busy));
            check_val("pend_hi", 32'(pend_hi), 32'(got.pend));
            check_val("pend_lo", 32'(pend_lo), 32'(got.pend));
            check_val("ovf_hi",  32'(ovf_hi),  32'(got.ovf));
            check_val("ovf_lo",  32'(ovf_lo),  32'(got.ovf));
        end
        if (led_hi && !prev_led) blinks++;
        prev_led = led_hi;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst_n    = 1'b0;
        event_in = 1'b0;
        clear_in = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b0);
        check_val("rst_led_hi",   32'(led_hi),  32'd0);
        check_val("rst_led_lo",   32'(led_lo),  32'd1);
        check_val("rst_busy",     32'(busy_hi), 32'd0);
        check_val("rst_pending",  32'(pend_hi), 32'd0);
        check_val("rst_overflow", 32'(ovf_hi),  32'd0);

        // Single event
        idle(4);
        blinks = 0;
        step(1'b1, 1'b0, 1'b1);
        idle(30);
        check_val("single_blinks", 32'(blinks), 32'd1);

        // Burst of three
        blinks = 0;
        repeat (3) step(1'b1, 1'b0, 1'b1);
        check_val("burst_pending", 32'(pend_hi), 32'd2);
        idle(70);
        check_val("burst_blinks", 32'(blinks), 32'd3);

        // Saturation: one start plus six queued
        blinks = 0;
        repeat (7) step(1'b1, 1'b0, 1'b1);
        check_val("sat_pending",  32'(pend_hi), 32'd3);
        check_val("sat_overflow", 32'(ovf_hi),  32'd1);
        idle(100);
        check_val("sat_blinks",      32'(blinks),  32'd4);
        check_val("sat_ovf_sticky",  32'(ovf_hi),  32'd1);
        check_val("sat_idle",        32'(busy_hi), 32'd0);

        // Clear mid-ON with a simultaneous event
        blinks = 0;
        repeat (3) step(1'b1, 1'b0, 1'b1);
        idle(2);
        step(1'b1, 1'b1, 1'b1);
        check_val("clr_pending",  32'(pend_hi), 32'd0);
        check_val("clr_overflow", 32'(ovf_hi),  32'd0);
        idle(40);
        check_val("clr_blinks", 32'(blinks), 32'd1);

        // Event on the last GAP cycle
        blinks = 0;
        step(1'b1, 1'b0, 1'b1);
        idle(c_on_n + c_off_n - 1);
        step(1'b1, 1'b0, 1'b1);
        check_val("fgap_busy",    32'(busy_hi), 32'd1);
        check_val("fgap_led",     32'(led_hi),  32'd1);
        check_val("fgap_pending", 32'(pend_hi), 32'd0);
        idle(45);
        check_val("fgap_blinks", 32'(blinks), 32'd2);

        // Reset at lit cycle 4 with two queued
        blinks = 0;
        repeat (3) step(1'b1, 1'b0, 1'b1);
        idle(1);
        step(1'b0, 1'b0, 1'b0);
        check_val("rmid_led_hi",  32'(led_hi),  32'd0);
        check_val("rmid_led_lo",  32'(led_lo),  32'd1);
        check_val("rmid_busy",    32'(busy_hi), 32'd0);
        check_val("rmid_pending", 32'(pend_hi), 32'd0);
        idle(40);
        check_val("rmid_blinks", 32'(blinks), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_pulse_driver.md
# led_pulse_driver

Output-side counterpart of the switch debouncer. It converts single-cycle internal event pulses into human-visible blinks on a physical LED pin. Each event becomes one blink with a guaranteed minimum ON time and a guaranteed minimum OFF gap. Bursts are queued in a saturating pending counter so that k events produce k distinct blinks. It sits between control logic (status/event strobes) and the board LED pins.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `ON_MS`, default 100: blink ON time in ms. ON_COUNT = (CLK_FREQ/1000)*ON_MS cycles.
- `OFF_MS`, default 100: minimum OFF gap after each blink, in ms. OFF_COUNT = (CLK_FREQ/1000)*OFF_MS cycles.
- `MAX_PENDING`, default 15: queued-event capacity, ≥1. PW = $clog2(MAX_PENDING+1).
- `LED_ACTIVE_HIGH`, default 1: 1 means the pin is high when lit; 0 means the pin is low when lit.
- `clk` in 1: system clock. This is the only clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `event_in` in 1: event strobe. Every cycle it is sampled high counts as one event.
- `clear_in` in 1: drops queued events and clears `overflow`.
- `led_out` out 1: LED pin, polarity set by `LED_ACTIVE_HIGH`.
- `busy` out 1: high when the state is not IDLE.
- `pending` out PW: number of queued events not yet blinked.
- `overflow` out 1: sticky flag, set when an event is lost to saturation.

## Operation
- The FSM has three states: IDLE, ON, GAP. A 32-bit cycle timer is loaded on each state entry.
- IDLE + event_in: go to ON with timer = ON_COUNT-1. `pending` is unchanged.
- ON: LED is lit. When the timer reaches 0, go to GAP with timer = OFF_COUNT-1.
- GAP: LED is dark. When the timer reaches 0:
  - if `pending` > 0 or `event_in` = 1, go to ON; `pending` becomes pending + event_in − 1.
  - otherwise go to IDLE.
- event_in in ON or GAP, outside the final-GAP case above: `pending` += 1.
  - If `pending` is already MAX_PENDING, it holds and `overflow` is set to 1.
- clear_in (any state): `pending` ← 0 and `overflow` ← 0.
  - `event_in` in the same cycle is discarded.
  - The current ON/GAP phase completes normally, then the FSM returns to IDLE.
- The FSM never shortens a phase. ON is exactly ON_COUNT cycles. Every blink is followed by at least OFF_COUNT dark cycles.
- Reset values: state IDLE, timer 0, `pending` 0, `overflow` 0, `busy` 0, `led_out` = ~LED_ACTIVE_HIGH (dark).
- Reset asserted mid-blink: the next cycle shows the dark LED; all queued events are lost and `overflow` is cleared.
- `led_out` is driven directly from a flop: no combinational path from inputs to the pin.

## Timing
- Event sampled at edge k while in IDLE: `led_out` is lit in cycles k+1 … k+ON_COUNT, dark from k+ON_COUNT+1 for OFF_COUNT cycles.
- `busy` rises together with the first lit cycle. It falls in the first cycle after the final GAP cycle when nothing is queued.
- Back-to-back blinks: the next lit cycle immediately follows the last GAP cycle. Period = ON_COUNT + OFF_COUNT.
- `pending` and `overflow` update on the edge that samples the event. There is no extra latency.

## Structure
- Package `led_pkg` holds:
  - the state enum {IDLE, ON, GAP};
  - the `ms_to_cycles(clk_freq, ms)` constant function.
- Sub-module `cycle_timer`: a loadable 32-bit down-counter with a `done` output (count == 0). It is used once here and is reusable by the debouncer family.
- The pending saturating counter, the overflow flag and the FSM live in the top level.

## Test plan
Bench parameters: CLK_FREQ=10_000, ON_MS=1, OFF_MS=1 (ON_COUNT = OFF_COUNT = 10), MAX_PENDING=3.
- **Single event:** event at edge 5 → `led_out` lit cycles 6–15, dark 16–25. `busy` is high 6–25, low at 26. `pending` stays 0.
- **Burst:** events at edges 5, 6, 7 → `pending` 1 then 2. Three blinks start at cycles 6, 26, 46. `pending` steps 2→1→0 at edges 25 and 45.
- **Saturation:** 6 events during the first ON → `pending` = 3 and `overflow` = 1. Exactly 4 blinks total, then IDLE; `overflow` stays 1.
- **Clear:** with `pending` = 2, `clear_in` mid-ON together with `event_in` → `pending` 0, `overflow` 0. The current blink finishes (10 lit + 10 dark), then IDLE with no further blinks.
- **Final-GAP event:** `event_in` exactly on the last GAP cycle with `pending` = 0 → a new blink starts the next cycle. `pending` stays 0 and `busy` never drops.
- **Reset mid-ON:** `rst_n` low for 1 cycle at lit cycle 4 with `pending` = 2 → `led_out` dark next cycle; `pending` 0, `busy` 0, no further blinks. Repeat with LED_ACTIVE_HIGH=0 to check the inverted pin levels.
